lsu_align_unit: RTL and testbench
=================================

// Module: lsu_align_unit
// PURPOSE
//   Sequential load/store alignment unit between the core's memory stage and the data-memory port.
//   - Extends the combinational load/store extender with byte-lane steering from the address offset.
//   - Generates byte enables and uses a request/grant memory handshake.
//   - Sign/zero-extends loads. Splits misaligned accesses into two aligned beats (optional).
// PARAMETERS
//   WIDTH   32  data/word width; 32 or 64 (NB = WIDTH/8 byte lanes, OFS = log2(NB))
//   ADDR_W  32  byte-address width
// PORTS
//   clk         in   1        clock; all state updates on rising edge
//   rst         in   1        synchronous, active-high reset
//   req_valid   in   1        core request valid
//   req_ready   out  1        unit idle, can accept a request
//   req_we      in   1        1 = store, 0 = load
//   req_funct3  in   3        RISC-V funct3 (size in [1:0], unsigned in [2])
//   req_addr    in   ADDR_W   byte address
//   req_wdata   in   WIDTH    store data, right-justified
//   resp_valid  out  1        one-cycle completion pulse
//   resp_rdata  out  WIDTH    extended load result (0 for stores/errors)
//   resp_err    out  1        illegal funct3 or unsupported misalignment
//   mem_req     out  1        memory beat request
//   mem_gnt     in   1        memory accepts beat this cycle
//   mem_we      out  1        beat is a write
//   mem_addr    out  ADDR_W   word-aligned beat address (low OFS bits 0)
//   mem_be      out  NB       byte enables
//   mem_wdata   out  WIDTH    lane-steered store data
//   mem_rvalid  in   1        read data valid (>=1 cycle after gnt)
//   mem_rdata   in   WIDTH    read word
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1; all other outputs 0; latched request cleared.
//   - FSM: IDLE -> REQ0 -> (load) WAIT0 -> [REQ1 -> WAIT1] -> RESP -> IDLE.
//     Store: REQ0 -gnt-> [REQ1 -gnt->] RESP.
//   - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata.
//   - Legal funct3 (WIDTH=32): 000,001,010,100,101. WIDTH=64 adds 011 (D) and 110 (WU).
//     Stores accept only funct3[2]=0.
//   - Illegal funct3: IDLE -> RESP with resp_err=1 and no memory beat.
//   - size = 1<<funct3[1:0] bytes; off = addr[OFS-1:0]; misaligned when off+size > NB.
//   - REQ states: mem_req=1; addr/be/wdata/we held stable until mem_gnt.
//     mem_gnt may stay low for any number of cycles.
//   - Beat0: mem_addr = addr & ~(NB-1); mem_be = ((1<<size)-1) << off, truncated to NB;
//     mem_wdata = wdata << 8*off; unused lanes are 0.
//   - Beat1 (split only): mem_addr = beat0 addr + NB; mem_be low (off+size-NB) lanes;
//     mem_wdata = wdata >> 8*(NB-off).
//   - WAIT states: capture mem_rdata on mem_rvalid. mem_rvalid is ignored in all other states.
//   - Load result: raw = {beat1,beat0} >> 8*off (beat1 = 0 if unsplit).
//     Mask to size bytes; sign-extend if funct3[2]=0, else zero-extend.
//   - RESP: resp_valid=1 for exactly one cycle, then IDLE (req_ready returns the next cycle).
//   - Min latency, aligned load with gnt at first REQ cycle and rvalid one cycle later:
//     accept T, mem_req T+1, rvalid T+2, resp_valid T+3.
//   - Min latency, aligned store: resp_valid at T+2.
//   - Reset mid-operation: transaction abandoned, no resp_valid. A late mem_rvalid lands in IDLE and is ignored.
// CONFIGURATION
//   MISALIGN_SPLIT_EN defined: misaligned legal accesses run as two beats (beat0, beat1).
//     Load data is merged from both beats; resp_err=0.
//   MISALIGN_SPLIT_EN undefined: misaligned access goes IDLE -> RESP with resp_err=1.
//     resp_rdata=0, mem_req never asserted; REQ1/WAIT1 are not built.
// TESTING (WIDTH=32, gnt same cycle as req, rvalid next cycle unless stated)
//   1 LB  addr 0x1003, mem[0x1000]=0x8011_2233 -> mem_be=4'b1000, resp_rdata=0xFFFF_FF80, err=0
//   2 LHU addr 0x1002, mem[0x1000]=0x9BDF_C000 -> mem_be=4'b1100, resp_rdata=0x0000_9BDF
//   3 SB  addr 0x2001, wdata=0x0000_00AB -> mem_we=1, mem_be=4'b0010, mem_wdata=0x0000_AB00
//   4 LW  addr 0x1002, mem[0x1000]=0xAABB_CCDD, mem[0x1004]=0x1122_3344:
//     with EN -> beats at 0x1000 (be 1100) and 0x1004 (be 0011), resp_rdata=0x3344_AABB;
//     without EN -> no mem_req, resp_err=1, resp_rdata=0
//   5 SW addr 0x3000 with mem_gnt low 3 cycles -> mem_req/addr/be=4'b1111/wdata stable all 4 cycles,
//     resp_valid 1 cycle after gnt; funct3=3'b011 -> resp_err=1, no mem_req
//   6 rst high during WAIT0 of LW -> next cycle req_ready=1, mem_req=0;
//     rvalid 2 cycles later ignored, no resp_valid

Source files
------------

// File: rtl/lsu_align_unit.sv
// lsu_align_unit: load/store alignment between the memory stage and the data-memory port.
// Define MISALIGN_SPLIT_EN to run misaligned accesses as two aligned beats.
//
// state  | meaning
// IDLE   | ready for a request
// REQ0   | first beat requested, held until mem_gnt
// WAIT0  | load: waiting for first beat read data
// REQ1   | second beat of a split access (split build only)
// WAIT1  | load: waiting for second beat read data (split build only)
// RESP   | one-cycle completion pulse
module lsu_align_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 resp_valid,
  output logic [WIDTH-1:0]     resp_rdata,
  output logic                 resp_err,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WIDTH/8-1:0]   mem_be,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [WIDTH-1:0]     mem_rdata
);

  localparam int NB  = WIDTH / 8;
  localparam int OFS = $clog2(NB);
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_RESP  = 3'd3
`ifdef MISALIGN_SPLIT_EN
    , S_REQ1  = 3'd4
    , S_WAIT1 = 3'd5
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    rd0_q, rd0_d;
  logic [WIDTH-1:0]    rd1_q, rd1_d;
`ifdef MISALIGN_SPLIT_EN
  logic                split_q, split_d;
`endif

  logic                in_legal, in_mis;
  logic [3:0]          in_size;
  logic [OFS-1:0]      off;
  logic [3:0]          size_b;
  logic [2*NB-1:0]     be_full;
  logic [WIDTH-1:0]    wd_mask;
  logic [2*WIDTH-1:0]  wd_wide;
  logic [WIDTH-1:0]    rd_raw, ld_val;
  logic                ld_sign;
  logic [ADDR_W-1:0]   base;
  logic                beat1;

  // Decode of the incoming request, used only at acceptance.
  always_comb begin
    in_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: in_legal = 1'b1;
      3'b100, 3'b101:         in_legal = !req_we;
      3'b011:                 in_legal = (WIDTH == 64);
      3'b110:                 in_legal = (WIDTH == 64) && !req_we;
      default:                in_legal = 1'b0;
    endcase
    in_size = 4'd1 << req_funct3[1:0];
    in_mis  = (int'(req_addr[OFS-1:0]) + int'(in_size)) > NB;
  end

  // Lane steering over a double-width window: low half is beat0, high half beat1.
  always_comb begin
    off     = addr_q[OFS-1:0];
    size_b  = 4'd1 << f3_q[1:0];
    base    = {addr_q[ADDR_W-1:OFS], {OFS{1'b0}}};
    be_full = '0;
    for (int i = 0; i < 2*NB; i++)
      be_full[i] = (i >= int'(off)) && (i < int'(off) + int'(size_b));
    wd_mask = '0;
    for (int i = 0; i < NB; i++)
      wd_mask[8*i +: 8] = (i < int'(size_b)) ? wdata_q[8*i +: 8] : 8'h00;
    wd_wide = {{WIDTH{1'b0}}, wd_mask} << {off, 3'b000};
    rd_raw  = WIDTH'({rd1_q, rd0_q} >> {off, 3'b000});
    ld_sign = 1'b0;
    for (int i = 0; i < NB; i++)
      if (i == int'(size_b) - 1) ld_sign = rd_raw[8*i+7] & ~f3_q[2];
    ld_val = '0;
    for (int i = 0; i < NB; i++)
      ld_val[8*i +: 8] = (i < int'(size_b)) ? rd_raw[8*i +: 8] : {8{ld_sign}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
`ifdef MISALIGN_SPLIT_EN
      split_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
`ifdef MISALIGN_SPLIT_EN
      split_q <= split_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
`ifdef MISALIGN_SPLIT_EN
    split_d = split_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = !in_legal || (in_mis && !SPLIT_EN);
          rd0_d   = '0;
          rd1_d   = '0;
`ifdef MISALIGN_SPLIT_EN
          split_d = in_legal && in_mis;
`endif
          state_d = (!in_legal || (in_mis && !SPLIT_EN)) ? S_RESP : S_REQ0;
        end
      end
      S_REQ0: begin
        if (mem_gnt) begin
          if (!we_q) state_d = S_WAIT0;
`ifdef MISALIGN_SPLIT_EN
          else       state_d = split_q ? S_REQ1 : S_RESP;
`else
          else       state_d = S_RESP;
`endif
        end
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
          rd0_d = mem_rdata;
`ifdef MISALIGN_SPLIT_EN
          state_d = split_q ? S_REQ1 : S_RESP;
`else
          state_d = S_RESP;
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      S_REQ1: begin
        if (mem_gnt) state_d = we_q ? S_RESP : S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          rd1_d   = mem_rdata;
          state_d = S_RESP;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef MISALIGN_SPLIT_EN
    beat1 = (state_q == S_REQ1);
`else
    beat1 = 1'b0;
`endif
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_err   = resp_valid && err_q;
    resp_rdata = (resp_valid && !err_q && !we_q) ? ld_val : '0;
    mem_req    = (state_q == S_REQ0) || beat1;
    mem_we     = mem_req && we_q;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    if (beat1) begin
      mem_addr  = base + ADDR_W'(NB);
      mem_be    = be_full[2*NB-1:NB];
      mem_wdata = wd_wide[2*WIDTH-1:WIDTH];
    end else if (mem_req) begin
      mem_addr  = base;
      mem_be    = be_full[NB-1:0];
      mem_wdata = wd_wide[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Bench for lsu_align_unit (WIDTH=32): byte-addressed memory model, directed cases and random traffic.
module tb_lsu_align_unit;
  localparam int WIDTH = 32;
  localparam int ADDR_W = 32;
`ifdef MISALIGN_SPLIT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;

  always #5 clk = ~clk;

  lsu_align_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mem [0:255];

  logic [3:0]  o_be0;
  logic [31:0] o_wd0, o_addr0, o_addr1, o_rdata;
  logic        o_err, o_we0;
  int          o_nreq, o_lat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int bidx(input logic [31:0] a);
    return int'(a & 32'hFF);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem[bidx(a + 32'(i))];
    return w;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[bidx(a + 32'(i))] = w[8*i +: 8];
  endtask

  function automatic logic [31:0] extend(input logic [31:0] v, input int size, input bit uns);
    logic [31:0] mask;
    mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
    v = v & mask;
    if (!uns && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic dut_reset();
    rst = 1'b1; req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction: model computes expected beats/result from byte-level rules,
  // the loop plays the memory side and checks every cycle.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gmax, input int rvmax, input bit fixed);
    int size, nb, idx, gcnt, rv_cnt, k;
    bit legal, mis, err, done;
    logic [31:0] b_addr [2];
    logic [3:0]  b_be [2];
    logic [31:0] b_wd [2];
    logic [31:0] exp_rd, val, a, rv_addr;
    size = 1 << f3[1:0];
    case (f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !we;
      default:                legal = 1'b0;
    endcase
    mis = (int'(addr[1:0]) + size) > 4;
    err = !legal || (mis && !EN);
    nb = 0;
    b_addr[0] = addr & ~32'h3;
    b_addr[1] = b_addr[0] + 32'd4;
    b_be[0] = '0; b_be[1] = '0; b_wd[0] = '0; b_wd[1] = '0;
    val = '0;
    if (!err) begin
      nb = mis ? 2 : 1;
      for (int i = 0; i < size; i++) begin
        int bk, lane;
        a = addr + 32'(i);
        bk = ((a & ~32'h3) == b_addr[0]) ? 0 : 1;
        lane = int'(a[1:0]);
        b_be[bk][lane] = 1'b1;
        b_wd[bk][8*lane +: 8] = wdata[8*i +: 8];
        val[8*i +: 8] = mem[bidx(a)];
      end
    end
    exp_rd = (err || we) ? 32'h0 : extend(val, size, f3[2]);

    o_nreq = 0; o_lat = 0; o_be0 = '0; o_wd0 = '0; o_addr0 = '0; o_addr1 = '0; o_we0 = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    idx = 0; rv_cnt = 0; rv_addr = '0; done = 1'b0;
    gcnt = fixed ? gmax : $urandom_range(0, gmax);
    for (k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = word_at(rv_addr); end
      end
      if (resp_valid) begin
        done = 1'b1; o_lat = k; o_rdata = resp_rdata; o_err = resp_err;
        chk("resp_err", resp_err, err);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("beats_done", 64'(idx), 64'(nb));
        chk("reads_done", 64'(rv_cnt), 64'd0);
      end else if (mem_req) begin
        o_nreq++;
        if (idx < nb) begin
          chk("mem_addr", mem_addr, b_addr[idx]);
          chk("mem_be", mem_be, b_be[idx]);
          chk("mem_wdata", mem_wdata, b_wd[idx]);
          chk("mem_we", mem_we, we);
          if (idx == 0) begin o_be0 = mem_be; o_wd0 = mem_wdata; o_addr0 = mem_addr; o_we0 = mem_we; end
          else o_addr1 = mem_addr;
          if (gcnt == 0) begin
            mem_gnt = 1'b1;
            if (!we) begin rv_cnt = fixed ? rvmax : $urandom_range(1, rvmax); rv_addr = b_addr[idx]; end
            idx++;
            gcnt = fixed ? gmax : $urandom_range(0, gmax);
          end else gcnt--;
        end else chk("extra_mem_req", mem_req, 1'b0);
        if (!mem_rvalid && rv_cnt == 0 && $urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
      end
    end
    if (!done) begin
      chk("resp_timeout", 1'b1, 1'b0);
      dut_reset();
    end else begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("resp_one_cycle", resp_valid, 1'b0);
      chk("ready_after_resp", req_ready, 1'b1);
      if (we && !err)
        for (int i = 0; i < size; i++) mem[bidx(addr + 32'(i))] = wdata[8*i +: 8];
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b0;

    // LB from top lane, sign-extended
    set_word(32'h1000, 32'h8011_2233);
    run_txn(1'b0, 3'b000, 32'h1003, 32'h0, 0, 1, 1'b1);
    chk("t1_be", o_be0, 4'b1000);
    chk("t1_rdata", o_rdata, 32'hFFFF_FF80);
    chk("t1_err", o_err, 1'b0);
    chk("t1_latency", 64'(o_lat), 64'd3);

    // LHU upper half
    set_word(32'h1000, 32'h9BDF_C000);
    run_txn(1'b0, 3'b101, 32'h1002, 32'h0, 0, 1, 1'b1);
    chk("t2_be", o_be0, 4'b1100);
    chk("t2_rdata", o_rdata, 32'h0000_9BDF);

    // SB lane 1
    run_txn(1'b1, 3'b000, 32'h2001, 32'h0000_00AB, 0, 1, 1'b1);
    chk("t3_we", o_we0, 1'b1);
    chk("t3_be", o_be0, 4'b0010);
    chk("t3_wdata", o_wd0, 32'h0000_AB00);
    chk("t3_latency", 64'(o_lat), 64'd2);

    // misaligned LW
    set_word(32'h1000, 32'hAABB_CCDD);
    set_word(32'h1004, 32'h1122_3344);
    run_txn(1'b0, 3'b010, 32'h1002, 32'h0, 0, 1, 1'b1);
    if (EN) begin
      chk("t4_nreq", 64'(o_nreq), 64'd2);
      chk("t4_addr0", o_addr0, 32'h1000);
      chk("t4_be0", o_be0, 4'b1100);
      chk("t4_addr1", o_addr1, 32'h1004);
      chk("t4_rdata", o_rdata, 32'h3344_AABB);
      chk("t4_err", o_err, 1'b0);
    end else begin
      chk("t4_nreq", 64'(o_nreq), 64'd0);
      chk("t4_err", o_err, 1'b1);
      chk("t4_rdata", o_rdata, 32'h0);
    end

    // SW with grant held off three cycles, then illegal SD
    run_txn(1'b1, 3'b010, 32'h3000, 32'hCAFE_BABE, 3, 1, 1'b1);
    chk("t5_nreq", 64'(o_nreq), 64'd4);
    chk("t5_latency", 64'(o_lat), 64'd5);
    chk("t5_be", o_be0, 4'b1111);
    run_txn(1'b1, 3'b011, 32'h3000, 32'h1234_5678, 0, 1, 1'b1);
    chk("t5_sd_err", o_err, 1'b1);
    chk("t5_sd_nreq", 64'(o_nreq), 64'd0);

    // reset during WAIT0, late rvalid must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_req0", mem_req, 1'b1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("t6_wait0", mem_req, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_ready", req_ready, 1'b1);
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_no_resp", resp_valid, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("t6_late_rvalid", resp_valid, 1'b0);
      chk("t6_idle", req_ready, 1'b1);
    end

    // random traffic
    for (int n = 0; n < 150; n++) begin
      logic [2:0] f3;
      logic we;
      we = 1'($urandom);
      f3 = 3'($urandom);
      run_txn(we, f3, 32'h1000 | 32'($urandom_range(0, 247)), $urandom, 3, 3, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
